// File: rtl/alu_dispatch_pkg.sv
// Shared types and constants for the ALU array issue controller.
// Opcode values match the 3-bit instr encoding decoded by the alu lanes.
package alu_dispatch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } dispatch_state_t;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_MUL = 3'd2;
  localparam logic [2:0] OP_AND = 3'd3;
  localparam logic [2:0] OP_OR  = 3'd4;
  localparam logic [2:0] OP_XOR = 3'd5;

  localparam int DEFAULT_TIMEOUT = 64;

endpackage

// File: rtl/alu_dispatch.sv
// Issue controller for the execute ALU array: one vector command in flight,
// registered array drive, masked result capture, bounded wait with timeout.
module alu_dispatch
  import alu_dispatch_pkg::*;
#(
  parameter int N       = 32,
  parameter int Q       = 16,
  parameter int ALU_NUM = 8,
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [2:0]           cmd_instr,
  input  logic [ALU_NUM-1:0]   cmd_mask,
  input  logic [ALU_NUM*N-1:0] cmd_dataA,
  input  logic [ALU_NUM*N-1:0] cmd_dataB,
  output logic [ALU_NUM-1:0]   enable_alu,
  output logic [2:0]           instr,
  output logic [ALU_NUM*N-1:0] dataA,
  output logic [ALU_NUM*N-1:0] dataB,
  input  logic                 exec_valid,
  input  logic [ALU_NUM*N-1:0] exec_data,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [ALU_NUM*N-1:0] res_data,
  output logic [ALU_NUM-1:0]   res_mask,
  output logic                 res_timeout,
  output logic [1:0]           fsm_state
);

  localparam int VW = ALU_NUM * N;
  localparam int CW = $clog2(TIMEOUT);

  if (TIMEOUT < 2 || Q < 0 || Q >= N) begin : g_bad_params
    $error("alu_dispatch: TIMEOUT must be >= 2 and 0 <= Q < N");
  end

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; valid holds its payload stable until that edge.
  dispatch_state_t    state, state_next;
  logic [ALU_NUM-1:0] mask_q, mask_next;
  logic [CW-1:0]      cnt, cnt_next;
  logic [ALU_NUM-1:0] enable_next, res_mask_next;
  logic [2:0]         instr_next;
  logic [VW-1:0]      dataA_next, dataB_next, res_data_next;
  logic               res_valid_next, res_timeout_next;

  assign cmd_ready = (state == IDLE);
  assign fsm_state = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      mask_q      <= '0;
      cnt         <= '0;
      enable_alu  <= '0;
      instr       <= '0;
      dataA       <= '0;
      dataB       <= '0;
      res_valid   <= 1'b0;
      res_data    <= '0;
      res_mask    <= '0;
      res_timeout <= 1'b0;
    end else begin
      state       <= state_next;
      mask_q      <= mask_next;
      cnt         <= cnt_next;
      enable_alu  <= enable_next;
      instr       <= instr_next;
      dataA       <= dataA_next;
      dataB       <= dataB_next;
      res_valid   <= res_valid_next;
      res_data    <= res_data_next;
      res_mask    <= res_mask_next;
      res_timeout <= res_timeout_next;
    end
  end

  always_comb begin
    state_next       = state;
    mask_next        = mask_q;
    cnt_next         = cnt;
    enable_next      = enable_alu;
    instr_next       = instr;
    dataA_next       = dataA;
    dataB_next       = dataB;
    res_valid_next   = res_valid;
    res_data_next    = res_data;
    res_mask_next    = res_mask;
    res_timeout_next = res_timeout;

    case (state)
      IDLE: begin
        if (cmd_valid) begin
          instr_next = cmd_instr;
          dataA_next = cmd_dataA;
          dataB_next = cmd_dataB;
          mask_next  = cmd_mask;
          // An all-zero mask never touches the array: its valid is vacuously
          // true in that case and carries no information.
          if (cmd_mask != '0) begin
            enable_next = cmd_mask;
            state_next  = ISSUE;
          end else begin
            res_valid_next   = 1'b1;
            res_data_next    = '0;
            res_mask_next    = '0;
            res_timeout_next = 1'b0;
            state_next       = DONE;
          end
        end
      end
      ISSUE: begin
        cnt_next   = '0;
        state_next = WAIT;
      end
      WAIT: begin
        cnt_next = cnt + 1'b1;
        if (exec_valid) begin
          for (int i = 0; i < ALU_NUM; i++) begin
            res_data_next[i*N +: N] = mask_q[i] ? exec_data[i*N +: N] : '0;
          end
          res_mask_next    = mask_q;
          res_timeout_next = 1'b0;
          res_valid_next   = 1'b1;
          enable_next      = '0;
          state_next       = DONE;
        end else if (cnt == CW'(TIMEOUT - 1)) begin
          res_data_next    = '0;
          res_mask_next    = mask_q;
          res_timeout_next = 1'b1;
          res_valid_next   = 1'b1;
          enable_next      = '0;
          state_next       = DONE;
        end
      end
      DONE: begin
        if (res_ready) begin
          res_valid_next = 1'b0;
          state_next     = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: doc/alu_dispatch.md
# alu_dispatch

Issue controller on the front end of the `execute` ALU array. It accepts one vector command at a time through a valid/ready handshake and drives the array's `enable_alu`/`instr`/`dataA`/`dataB` inputs. It waits for the array's aggregate `valid`, captures the lane results, and returns them to the requester through a second valid/ready handshake. A bounded timeout guarantees forward progress if the array never signals completion.

## Interface
- `N`, 32, operand/result width per lane (signed fixed point)
- `Q`, 16, fractional bits; passed through, no arithmetic in this block
- `ALU_NUM`, 8, number of lanes
- `TIMEOUT`, 64, maximum cycles in WAIT before aborting; must be ≥ 2
- `clk` in 1: single clock, all logic on rising edge
- `rst` in 1: synchronous, active-high reset
- `cmd_valid` in 1: command present
- `cmd_ready` out 1: block can accept a command
- `cmd_instr` in 3: ALU opcode
- `cmd_mask` in ALU_NUM: lanes to enable
- `cmd_dataA`, `cmd_dataB` in ALU_NUM×N: packed signed operand vectors, lane i at [i]
- `enable_alu` out ALU_NUM: lane enables to the array
- `instr` out 3: opcode to the array
- `dataA`, `dataB` out ALU_NUM×N: operands to the array
- `exec_valid` in 1: the array's aggregate `valid`
- `exec_data` in ALU_NUM×N: the array's `data_out`
- `res_valid` out 1: result available
- `res_ready` in 1: consumer accepts the result
- `res_data` out ALU_NUM×N: captured results; disabled lanes read 0
- `res_mask` out ALU_NUM: echo of the issued mask
- `res_timeout` out 1: result was aborted by timeout; `res_data` is all zero

## Operation
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - `cmd_ready`=1.
  - On `cmd_valid`, latch instr, mask and operands into the issue registers.
  - If mask≠0, go to ISSUE.
  - If mask==0, go directly to DONE with `res_data`=0, `res_mask`=0, `res_timeout`=0. The array is never enabled. The array's `valid` is trivially 1 when the mask is zero and must not be trusted.
- ISSUE:
  - `enable_alu`=mask; instr and operands driven from the issue registers.
  - `exec_valid` is ignored in this state, which discards any stale lane-valid from the previous op.
  - Clear the timeout counter. Next state is WAIT.
- WAIT:
  - `enable_alu`, `instr` and operands are held stable.
  - The counter increments each cycle.
  - If `exec_valid`=1: capture `exec_data` into `res_data`, masking off disabled lanes to 0. Set `res_timeout`=0 and go to DONE.
  - Else, if counter == TIMEOUT−1: set `res_data`=0, `res_timeout`=1 and go to DONE.
  - If `exec_valid` rises on the same cycle the timeout expires, the result wins.
- DONE:
  - `enable_alu`=0; `res_valid`=1.
  - On `res_ready`, go to IDLE.
  - `res_*` outputs hold stable while `res_valid`=1 and `res_ready`=0.
- `cmd_ready`=0 in every state except IDLE. There is no pipelining: one command in flight.
- Reset in any state: go to IDLE on the next edge and drop `enable_alu` immediately. An in-flight result is lost; no partial response is produced.

## Timing
- Reset values:
  - state=IDLE, `cmd_ready`=1, `enable_alu`=0, `instr`=0
  - `dataA`=`dataB`=0
  - `res_valid`=0, `res_data`=0, `res_mask`=0, `res_timeout`=0
- All outputs are registered, except `cmd_ready`, which is decoded from the state register.
- Cycle timeline, with the command accepted at edge t:
  - ISSUE occupies cycle t+1.
  - The earliest capture is at the t+2 edge.
  - The earliest `res_valid` is cycle t+3.
- A mask==0 command gives `res_valid` in cycle t+1.
- Worst case, the timeout path: `res_valid` at cycle t+2+TIMEOUT.
- Minimum throughput is 1 command per 4 cycles with `res_ready` held high.
- `res_ready` may be high before `res_valid`.
- No combinational path exists from `exec_valid` or `cmd_valid` to any output.

## Structure
- `alu_dispatch_pkg` holds:
  - the state enum `dispatch_state_t`
  - opcode localparams shared with `alu` (3-bit `instr` encoding)
  - the default `TIMEOUT`
- No sub-module is required.
- The timeout counter width is $clog2(TIMEOUT).

## Test plan
- Single op: mask=8'hFF, instr=ADD, A[i]=i<<16, B[i]=1<<16. Model array asserts valid 2 cycles after enable. Expect `res_data[i]`=(i+1)<<16 and `res_valid` at t+4.
- Partial mask: mask=8'h05, model drives all lanes' `data_out` with 32'hDEAD. Expect `res_data` lanes 0 and 2 = DEAD, others 0, `res_mask`=05.
- Zero mask: mask=0. `enable_alu` never leaves 0; `res_valid` at t+1, `res_data`=0.
- Timeout: model never asserts valid, TIMEOUT=8. Expect `res_timeout`=1, `res_data`=0, and `res_valid` exactly 10 cycles after accept.
- Backpressure: hold `res_ready`=0 for 5 cycles. `res_*` stay stable, `cmd_ready`=0, and a new `cmd_valid` is not accepted until the cycle after the handshake.
- Reset mid-WAIT: assert `rst` for 1 cycle. Next cycle state=IDLE, `enable_alu`=0, `res_valid`=0; a later `exec_valid` pulse is ignored.
